// File: rtl/i2c_target_pkg.sv
// Shared state encoding, debug view and bus constants for the I2C/SCCB register target.
package i2c_target_pkg;

  localparam int   BITS_PER_BYTE = 8;
  localparam logic ACK           = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_ACK_DEV,
    ST_SUB_ADDR,
    ST_WR_DATA,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

  // ack_phase marks the 9th-bit window of a received byte; in RD_DATA it
  // means "first data bit of the reloaded byte not yet driven".
  typedef struct packed {
    state_e     state;
    logic       ack_phase;
    logic [7:0] ptr;
  } fsm_dbg_t;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizer plus edge register for one asynchronous bus line.
module i2c_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  // Idle bus level is high, so reset to ones to avoid a spurious edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= 3'b111;
    else         sync_q <= {sync_q[1:0], line_i};
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/i2c_reg_target.sv
// I2C/SCCB target with a 256x8 register file, sub-address pointer and host read port.
module i2c_reg_target
  import i2c_target_pkg::*;
#(
  parameter logic [7:0] DEVICE_ID = 8'h42,
  parameter logic [7:0] RST_VAL   = 8'h00
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output fsm_dbg_t   dbg
);

  localparam logic [3:0] LAST_BIT  = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0] FULL_BYTE = 4'(BITS_PER_BYTE);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det, byte_done;
  logic [7:0] byte_d, ptr_nxt;

  state_e     state_q;
  logic       ack_phase_q, rw_q, sda_out_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] tx_q, ptr_q;
  logic       wr_strobe_q;
  logic [7:0] wr_addr_q, wr_data_q;
  logic [7:0] regs_q [256];

  i2c_line_sync u_scl_sync (
    .clk_i(Clk), .rst_ni(Rst_n), .line_i(i2c_sclk),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync u_sda_sync (
    .clk_i(Clk), .rst_ni(Rst_n), .line_i(i2c_sdat),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_d    = {shift_q, sda_lvl};
  assign byte_done = (bit_cnt_q == LAST_BIT);
  assign ptr_nxt   = ptr_q + 8'd1;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      ack_phase_q <= 1'b0;
      rw_q        <= 1'b0;
      sda_out_q   <= 1'b1;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      ptr_q       <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      for (int i = 0; i < 256; i++) regs_q[i] <= RST_VAL;
    end else begin
      wr_strobe_q <= 1'b0;
      if (start_det) begin
        state_q     <= ST_DEV_ADDR;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        sda_out_q   <= 1'b1;
      end else if (stop_det) begin
        state_q     <= ST_IDLE;
        bit_cnt_q   <= '0;
        ack_phase_q <= 1'b0;
        sda_out_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_DEV_ADDR: if (scl_rise) begin
            shift_q   <= byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (byte_done) begin
              if (byte_d[7:1] == DEVICE_ID[7:1]) begin
                state_q <= ST_ACK_DEV;
                rw_q    <= byte_d[0];
              end else begin
                state_q <= ST_IGNORE;
              end
            end
          end
          // First fall drives ACK, the fall after the 9th clock hands the line on.
          ST_ACK_DEV: if (scl_fall) begin
            if (sda_out_q) begin
              sda_out_q <= ACK;
            end else if (rw_q) begin
              tx_q        <= regs_q[ptr_q];
              sda_out_q   <= regs_q[ptr_q][7];
              state_q     <= ST_RD_DATA;
              bit_cnt_q   <= '0;
              ack_phase_q <= 1'b0;
            end else begin
              sda_out_q <= 1'b1;
              state_q   <= ST_SUB_ADDR;
              bit_cnt_q <= '0;
            end
          end
          ST_SUB_ADDR, ST_WR_DATA: begin
            if (!ack_phase_q && scl_rise) begin
              shift_q   <= byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (byte_done) begin
                ack_phase_q <= 1'b1;
                if (state_q == ST_SUB_ADDR) begin
                  ptr_q <= byte_d;
                end else begin
                  regs_q[ptr_q] <= byte_d;
                  wr_strobe_q   <= 1'b1;
                  wr_addr_q     <= ptr_q;
                  wr_data_q     <= byte_d;
                  ptr_q         <= ptr_nxt;
                end
              end
            end else if (ack_phase_q && scl_fall) begin
              if (sda_out_q) begin
                sda_out_q <= ACK;
              end else begin
                sda_out_q   <= 1'b1;
                ack_phase_q <= 1'b0;
                bit_cnt_q   <= '0;
                state_q     <= ST_WR_DATA;
              end
            end
          end
          ST_RD_DATA: begin
            if (ack_phase_q) begin
              if (scl_fall) begin
                sda_out_q   <= tx_q[7];
                ack_phase_q <= 1'b0;
              end
            end else if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == FULL_BYTE) begin
                sda_out_q <= 1'b1;
                state_q   <= ST_RD_ACK;
                bit_cnt_q <= '0;
              end else begin
                tx_q      <= {tx_q[6:0], 1'b0};
                sda_out_q <= tx_q[6];
              end
            end
          end
          ST_RD_ACK: if (scl_rise) begin
            if (sda_lvl == ACK) begin
              ptr_q       <= ptr_nxt;
              tx_q        <= regs_q[ptr_nxt];
              state_q     <= ST_RD_DATA;
              bit_cnt_q   <= '0;
              ack_phase_q <= 1'b1;
            end else begin
              state_q <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // wr_strobe is a valid-only pulse: one Clk per committed byte, no back-pressure.
  assign i2c_sdat  = sda_out_q ? 1'bz : 1'b0;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_data   = regs_q[rd_addr];
  assign busy      = (state_q != ST_IDLE);
  assign dbg       = '{state: state_q, ack_phase: ack_phase_q, ptr: ptr_q};

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bit-banged I2C master driving i2c_reg_target against a transaction-level register model.
module tb_i2c_reg_target;
  import i2c_target_pkg::*;

  localparam int         Q     = 100;
  localparam logic [7:0] DEV_W = 8'h42;
  localparam logic [7:0] DEV_R = 8'h43;
  localparam logic [7:0] RST_V = 8'h00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_low = 1'b0;
  wire        sda;
  logic       wr_strobe, busy;
  logic [7:0] wr_addr, wr_data, rd_data;
  logic [7:0] rd_addr = 8'h00;
  fsm_dbg_t   dbg;

  assign sda = sda_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_reg_target #(.DEVICE_ID(8'h42), .RST_VAL(RST_V)) dut (
    .Clk(clk), .Rst_n(rst_n), .i2c_sclk(scl), .i2c_sdat(sda),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .dbg(dbg)
  );

  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [7:0]  model_regs [256];
  logic [7:0]  model_ptr;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int checks = 0;
  int failures = 0;
  int wide_strobes = 0;
  int dut_lows = 0;
  logic strobe_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_strobe) got_q.push_back({wr_addr, wr_data});
    if (wr_strobe && strobe_prev) wide_strobes++;
    if (sda == 1'b0 && !sda_low) dut_lows++;
    strobe_prev <= wr_strobe;
  end

  // ---------------- bus driver tasks ----------------
  task automatic bus_start();
    sda_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_rstart();
    sda_low = 1'b0; #Q; scl = 1'b1; #Q; sda_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; #Q; scl = 1'b1; #Q; sda_low = 1'b0; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    sda_low = !b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    sda_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic bt;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      get_bit(bt);
      b = {b[6:0], bt};
    end
    put_bit(nack);
  endtask

  // Write n data bytes starting at sub (n=0 only sets the pointer); model follows.
  task automatic txn_write(input logic [7:0] sub, input logic [7:0] d[4], input int n,
                           output int nacks);
    logic a;
    nacks = 0;
    bus_start();
    write_byte(DEV_W, a); nacks += int'(a);
    write_byte(sub, a);   nacks += int'(a);
    model_ptr = sub;
    for (int i = 0; i < n; i++) begin
      write_byte(d[i], a); nacks += int'(a);
      model_regs[model_ptr] = d[i];
      exp_q.push_back({model_ptr, d[i]});
      model_ptr = model_ptr + 8'd1;
    end
    bus_stop();
  endtask

  // Read n bytes (master ACKs all but the last); optional sub-address plus repeated START.
  task automatic txn_read(input int n, input logic [7:0] sub, input logic rep,
                          output logic [7:0] got[4], output int nacks);
    logic a;
    nacks = 0;
    for (int i = 0; i < 4; i++) got[i] = 8'h00;
    bus_start();
    if (rep) begin
      write_byte(DEV_W, a); nacks += int'(a);
      write_byte(sub, a);   nacks += int'(a);
      bus_rstart();
    end
    write_byte(DEV_R, a); nacks += int'(a);
    for (int i = 0; i < n; i++) read_byte(got[i], (i == n - 1));
    bus_stop();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 256; i++) model_regs[i] = RST_V;
    model_ptr = 8'h00;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", wr_strobe); end
    checks++; if (wr_addr !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", wr_addr); end
    checks++; if (wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", wr_data); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
    checks++; if (dbg.state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg.state, ST_IDLE); end
    checks++; if (dbg.ptr !== 8'h00) begin failures++; $display("FAIL reset_ptr got=%h exp=00", dbg.ptr); end
    for (int i = 0; i < 256; i += 17) begin
      rd_addr = 8'(i); #1;
      checks++; if (rd_data !== RST_V) begin failures++; $display("FAIL reset_reg[%h] got=%h exp=%h", rd_addr, rd_data, RST_V); end
    end
  endtask

  task automatic test_single_write_read();
    logic a0, a1, a2;
    logic [7:0] b, e;
    logic [7:0] d[4];
    int nacks;
    logic [15:0] ge, gg;
    bus_start();
    write_byte(DEV_W, a0); write_byte(8'h12, a1); write_byte(8'h80, a2);
    bus_stop();
    model_regs[8'h12] = 8'h80; model_ptr = 8'h13; exp_q.push_back({8'h12, 8'h80});
    checks++; if (a0 !== ACK) begin failures++; $display("FAIL single_ack_dev got=%b exp=0", a0); end
    checks++; if (a1 !== ACK) begin failures++; $display("FAIL single_ack_sub got=%b exp=0", a1); end
    checks++; if (a2 !== ACK) begin failures++; $display("FAIL single_ack_data got=%b exp=0", a2); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL single_strobe_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gg = got_q.pop_front(); ge = exp_q.pop_front();
      checks++; if (gg !== ge) begin failures++; $display("FAIL single_strobe got=%h exp=%h", gg, ge); end
    end
    got_q.delete(); exp_q.delete();
    d = '{8'h00, 8'h00, 8'h00, 8'h00};
    txn_write(8'h12, d, 0, nacks);
    checks++; if (nacks != 0) begin failures++; $display("FAIL single_ptr_phase nacks got=%0d exp=0", nacks); end
    e = model_regs[model_ptr];
    bus_start(); write_byte(DEV_R, a0); read_byte(b, 1'b1); bus_stop();
    checks++; if (a0 !== ACK) begin failures++; $display("FAIL single_ack_rd got=%b exp=0", a0); end
    checks++; if (b !== e) begin failures++; $display("FAIL single_read got=%h exp=%h", b, e); end
    rd_addr = 8'h12; #1;
    checks++; if (rd_data !== model_regs[8'h12]) begin failures++; $display("FAIL single_host_rd got=%h exp=%h", rd_data, model_regs[8'h12]); end
    checks++; if (dbg.ptr !== model_ptr) begin failures++; $display("FAIL single_ptr got=%h exp=%h", dbg.ptr, model_ptr); end
  endtask

  task automatic test_burst_wrap();
    logic [7:0] d[4];
    int nacks;
    logic [15:0] ge, gg;
    d = '{8'hA1, 8'hA2, 8'hA3, 8'h00};
    txn_write(8'hFE, d, 3, nacks);
    checks++; if (nacks != 0) begin failures++; $display("FAIL burst_acks nacks got=%0d exp=0", nacks); end
    checks++; if (got_q.size() != 3) begin failures++; $display("FAIL burst_strobe_count got=%0d exp=3", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gg = got_q.pop_front(); ge = exp_q.pop_front();
      checks++; if (gg !== ge) begin failures++; $display("FAIL burst_strobe got=%h exp=%h", gg, ge); end
    end
    got_q.delete(); exp_q.delete();
    checks++; if (wide_strobes != 0) begin failures++; $display("FAIL strobe_width wide got=%0d exp=0", wide_strobes); end
    for (int i = 0; i < 3; i++) begin
      rd_addr = 8'(8'hFE + 8'(i)); #1;
      checks++; if (rd_data !== model_regs[rd_addr]) begin failures++; $display("FAIL burst_reg[%h] got=%h exp=%h", rd_addr, rd_data, model_regs[rd_addr]); end
    end
    checks++; if (dbg.ptr !== model_ptr) begin failures++; $display("FAIL burst_ptr got=%h exp=%h", dbg.ptr, model_ptr); end
  endtask

  task automatic test_wrong_device();
    logic a0, a1;
    int lows0;
    lows0 = dut_lows;
    bus_start();
    write_byte(8'h60, a0); write_byte(8'hFF, a1);
    checks++; if (a0 !== 1'b1) begin failures++; $display("FAIL wrongdev_nack got=%b exp=1", a0); end
    checks++; if (dut_lows != lows0) begin failures++; $display("FAIL wrongdev_sda_driven got=%0d exp=%0d", dut_lows, lows0); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wrongdev_busy_mid got=%b exp=1", busy); end
    bus_stop();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wrongdev_busy_stop got=%b exp=0", busy); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL wrongdev_strobe got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_rep_start_read();
    logic [7:0] d[4];
    logic [7:0] b0, b1;
    logic a0, a1, a2;
    int nacks;
    d = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
    txn_write(8'h05, d, 2, nacks);
    checks++; if (nacks != 0) begin failures++; $display("FAIL rep_preset nacks got=%0d exp=0", nacks); end
    got_q.delete(); exp_q.delete();
    bus_start();
    write_byte(DEV_W, a0); write_byte(8'h05, a1);
    bus_rstart();
    write_byte(DEV_R, a2);
    read_byte(b0, 1'b0); read_byte(b1, 1'b1);
    model_ptr = 8'h06;
    checks++; if ({a0, a1, a2} !== 3'b000) begin failures++; $display("FAIL rep_acks got=%b exp=000", {a0, a1, a2}); end
    checks++; if (b0 !== model_regs[8'h05]) begin failures++; $display("FAIL rep_byte0 got=%h exp=%h", b0, model_regs[8'h05]); end
    checks++; if (b1 !== model_regs[8'h06]) begin failures++; $display("FAIL rep_byte1 got=%h exp=%h", b1, model_regs[8'h06]); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rep_sda_release got=%b exp=1", sda); end
    checks++; if (dbg.state !== ST_IGNORE) begin failures++; $display("FAIL rep_state got=%0d exp=%0d", dbg.state, ST_IGNORE); end
    bus_stop();
    checks++; if (dbg.ptr !== model_ptr) begin failures++; $display("FAIL rep_ptr got=%h exp=%h", dbg.ptr, model_ptr); end
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rep_strobe got=%0d exp=0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_abort_stop();
    logic [7:0] s;
    logic a0, a1;
    s = 8'($urandom_range(16, 200));
    bus_start();
    write_byte(DEV_W, a0); write_byte(s, a1);
    for (int i = 0; i < 4; i++) put_bit(1'($urandom));
    bus_stop();
    model_ptr = s;
    rd_addr = s; #1;
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL abort_strobe got=%0d exp=0", got_q.size()); end
    checks++; if (rd_data !== model_regs[s]) begin failures++; $display("FAIL abort_reg got=%h exp=%h", rd_data, model_regs[s]); end
    checks++; if (dbg.ptr !== model_ptr) begin failures++; $display("FAIL abort_ptr got=%h exp=%h", dbg.ptr, model_ptr); end
    got_q.delete();
  endtask

  task automatic test_reset_abort();
    logic [7:0] s, v;
    logic a0, a1;
    logic [15:0] ge, gg;
    s = 8'($urandom);
    v = 8'($urandom_range(1, 255));
    bus_start();
    write_byte(DEV_W, a0); write_byte(s, a1);
    for (int i = 7; i >= 0; i--) put_bit(v[i]);
    model_regs[s] = v; exp_q.push_back({s, v});
    sda_low = 1'b0; #Q; scl = 1'b1; #Q;
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL rstab_ack got=%b exp=0", sda); end
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL rstab_strobe_count got=%0d exp=1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      gg = got_q.pop_front(); ge = exp_q.pop_front();
      checks++; if (gg !== ge) begin failures++; $display("FAIL rstab_strobe got=%h exp=%h", gg, ge); end
    end
    got_q.delete(); exp_q.delete();
    rst_n = 1'b0; #1;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL rstab_sda got=%b exp=1", sda); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstab_busy got=%b exp=0", busy); end
    for (int i = 0; i < 256; i++) model_regs[i] = RST_V;
    model_ptr = 8'h00;
    for (int i = 0; i < 256; i++) begin
      rd_addr = 8'(i); #1;
      checks++; if (rd_data !== model_regs[i]) begin failures++; $display("FAIL rstab_reg[%h] got=%h exp=%h", rd_addr, rd_data, model_regs[i]); end
    end
    scl = 1'b0; #Q;
    rst_n = 1'b1; #Q;
    bus_stop();
    got_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] d[4];
    logic [7:0] got[4];
    logic [7:0] exp_rd[4];
    logic [7:0] sub, start;
    logic [15:0] ge, gg;
    int n, nacks, kind;
    for (int it = 0; it < 9; it++) begin
      kind = int'($urandom_range(0, 2));
      sub  = 8'($urandom);
      n    = int'($urandom_range(1, 3));
      if (kind == 0) begin
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
        txn_write(sub, d, n, nacks);
        checks++; if (nacks != 0) begin failures++; $display("FAIL rand_wr_acks got=%0d exp=0", nacks); end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_strobe_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
          gg = got_q.pop_front(); ge = exp_q.pop_front();
          checks++; if (gg !== ge) begin failures++; $display("FAIL rand_strobe got=%h exp=%h", gg, ge); end
        end
        got_q.delete(); exp_q.delete();
      end else begin
        start = (kind == 2) ? sub : model_ptr;
        for (int i = 0; i < n; i++) exp_rd[i] = model_regs[8'(start + 8'(i))];
        txn_read(n, sub, (kind == 2), got, nacks);
        model_ptr = 8'(start + 8'(n - 1));
        checks++; if (nacks != 0) begin failures++; $display("FAIL rand_rd_acks got=%0d exp=0", nacks); end
        for (int i = 0; i < n; i++) begin
          checks++; if (got[i] !== exp_rd[i]) begin failures++; $display("FAIL rand_read[%0d] got=%h exp=%h", i, got[i], exp_rd[i]); end
        end
      end
      checks++; if (dbg.ptr !== model_ptr) begin failures++; $display("FAIL rand_ptr got=%h exp=%h", dbg.ptr, model_ptr); end
    end
    for (int i = 0; i < 16; i++) begin
      rd_addr = 8'($urandom); #1;
      checks++; if (rd_data !== model_regs[rd_addr]) begin failures++; $display("FAIL rand_host_rd[%h] got=%h exp=%h", rd_addr, rd_data, model_regs[rd_addr]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_write_read();
    test_burst_wrap();
    test_wrong_device();
    test_rep_start_read();
    test_abort_stop();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_reg_target.md
# i2c_reg_target

I2C/SCCB target (responder) with an internal 256×8 register file, answering the same 8-bit-sub-address register-write/read protocol that the sensor-init master issues. It sits on the FPGA side of the camera control bus. Uses:
- as a synthesizable OV7725-style register model for loopback simulation and on-board bring-up of the init path;
- as a host-accessible status/config register bank for the frame-difference pipeline.

## Interface
- `DEVICE_ID`, default `8'h42`: 8-bit write address. Read address is `DEVICE_ID|1`. Bit 0 of the parameter is ignored.
- `RST_VAL`, default `8'h00`: reset value of every register-file entry.
- `Clk` in, 1: system clock, ≥ 16× SCL frequency.
- `Rst_n` in, 1: asynchronous, active-low reset.
- `i2c_sclk` in, 1: bus clock from master, asynchronous to `Clk`.
- `i2c_sdat` inout, 1: open-drain data. The block only ever drives `1'b0` or `1'bz`.
- `wr_strobe` out, 1: one-`Clk` pulse per accepted data byte.
- `wr_addr` out, 8: register address written; valid with `wr_strobe`.
- `wr_data` out, 8: data written; valid with `wr_strobe`.
- `rd_addr` in, 8: host-side read port address, combinational.
- `rd_data` out, 8: register-file contents at `rd_addr`.
- `busy` out, 1: high from a detected START until STOP or return to IDLE.

## Operation
- **Input conditioning.** `i2c_sclk` and `i2c_sdat` each pass through a 2-FF synchronizer plus a third register. This yields `scl_rise`, `scl_fall`, `start` and `stop` pulses.
  - `start`: SDA falls while SCL is high.
  - `stop`: SDA rises while SCL is high.
- **START and STOP priority.** `start` from any state forces DEV_ADDR and clears the bit counter; this covers repeated START. `stop` from any state forces IDLE and releases SDA. Both override all other transitions in the same cycle.
- **Bit handling.** Data bits are sampled on `scl_rise`, MSB first. SDA drive changes only on `scl_fall`.
- **State machine:**
  - IDLE: wait for `start`.
  - DEV_ADDR: shift 8 bits. Then branch:
    - `byte[7:1] == DEVICE_ID[7:1]`: go to ACK_DEV and drive 0 for the 9th bit.
    - mismatch: go to IGNORE, release SDA, and wait for `start` or `stop`.
  - ACK_DEV:
    - R/W=0: go to SUB_ADDR.
    - R/W=1: load `tx = regs[ptr]` and go to RD_DATA.
  - SUB_ADDR: shift 8 bits, set `ptr <= byte`, ACK, go to WR_DATA.
  - WR_DATA: shift 8 bits, ACK, `regs[ptr] <= byte`, pulse `wr_strobe`, `ptr <= ptr+1`. Stay in WR_DATA.
  - RD_DATA: drive `tx` MSB first, releasing SDA for each 1 bit. After bit 0, release SDA and go to RD_ACK.
  - RD_ACK: sample the master's ACK on `scl_rise`.
    - ACK (0): `ptr <= ptr+1`, reload `tx` from the new `ptr`, go to RD_DATA.
    - NACK (1): go to IGNORE.
- **Pointer.** 8-bit, wraps `8'hFF → 8'h00`. It survives STOP, so a read without a preceding sub-address continues from the last `ptr` (SCCB 2-phase read). Reset value is `8'h00`.
- **Arbitration.** A host-side `rd_addr` read never stalls the bus. No host write port exists.

## Timing
- **Reset values.** `i2c_sdat` = Z, `wr_strobe` = 0, `wr_addr` = `wr_data` = 0, `busy` = 0, all registers = `RST_VAL`, state = IDLE, `ptr` = 0. Reset mid-transfer releases SDA immediately (asynchronous).
- **Input latency.** Bus edge to internal event is 3 `Clk` cycles.
- **ACK window.**
  - ACK drive begins within 4 `Clk` of the SCL falling edge that ends bit 0.
  - SDA is released within 4 `Clk` of the following SCL fall.
- **Write commit.** `wr_strobe` asserts for exactly 1 `Clk`, 3–4 `Clk` after the 8th data-bit rising edge. The register file updates in the same cycle.
- **`rd_data`** is combinational from the register array, which is LUT/FF-based (not block RAM).
- **Aborted byte.** A STOP or START arriving mid-byte discards the partial byte; no write occurs.

## Structure
- **Package `i2c_target_pkg`:** state encoding (IDLE, DEV_ADDR, ACK_DEV, SUB_ADDR, WR_DATA, RD_DATA, RD_ACK, IGNORE, plus an ACK sub-phase flag), and the constants `BITS_PER_BYTE = 8` and `ACK = 1'b0`.
- **Sub-module `i2c_line_sync`:** one instance per line, producing the synchronized level plus rise/fall pulses. START/STOP decode stays in the top level.

## Test plan
1. **Single write, then 2-phase read.** Write dev `0x42`, sub `0x12`, data `0x80`, STOP; then dev `0x43`, read 1 byte, NACK, STOP.
   - Three ACKs on the write.
   - One `wr_strobe` with `wr_addr=0x12`, `wr_data=0x80`.
   - Read returns `0x80`; `rd_addr=0x12` gives `rd_data=0x80`.
2. **Burst with wrap.** Sub `0xFE`, data `0xA1 0xA2 0xA3`.
   - `regs[FE]=A1`, `regs[FF]=A2`, `regs[00]=A3`.
   - Three strobes; final `ptr=0x01`.
3. **Wrong device.** Dev byte `0x60`.
   - SDA never driven low through the following byte.
   - No strobe; `busy` falls at STOP.
4. **Repeated-START read.** Dev `0x42`, sub `0x05`, then Sr, dev `0x43`, read 2 bytes (ACK, then NACK).
   - Returns `regs[05]`, then `regs[06]`.
   - SDA released after NACK.
5. **Aborts.**
   - STOP after 4 data bits of a write: no strobe, register unchanged.
   - `Rst_n` pulsed low during an ACK bit: SDA goes Z at once, all registers return to `0x00`.
